eth_rx_frame_parser: RTL and testbench

- Byte-serial GMII receive parser and the parametrised successor of the fixed 7-state parser.
- Accepts a variable-length preamble, extracts dest MAC, src MAC, optional 802.1Q tag and EtherType.
- Streams the payload with CRC bytes stripped through a 5-byte delay buffer.
- Reports per-frame status (error flags, payload length).
- Sits between the GMII RX pins (mac_if_pkg) and downstream MAC/filter logic.

---
 rtl/eth_rx_frame_parser.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_eth_rx_frame_parser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_parser.sv
// Byte-serial GMII receive parser: preamble/SFD check, MAC/EtherType extraction, FCS-stripped payload stream.
// Define ETH_PARSER_VLAN_EN to build 802.1Q tag parsing (VLAN_PARSE state, vlan_present/vlan_tci).
module eth_rx_frame_parser #(
  parameter int MIN_PREAMBLE_LEN    = 5,
  parameter int PREAMBLE_LEN        = 7,
  parameter int MIN_DATA_OR_CRC_LEN = 50,
  parameter int MAX_DATA_OR_CRC_LEN = 1504,
  parameter int LEN_W               = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic             hdr_valid,
  output logic [47:0]      dest_mac,
  output logic [47:0]      src_mac,
  output logic [15:0]      ether_type,
  output logic             vlan_present,
  output logic [15:0]      vlan_tci,
  output logic             pld_valid,
  output logic [7:0]       pld_data,
  output logic             pld_first,
  output logic             pld_last,
  output logic             frame_done,
  output logic [4:0]       frame_err,
  output logic [LEN_W-1:0] pld_len
);

  localparam int PC_W = $clog2(PREAMBLE_LEN + 1);
  localparam int DC_W = $clog2(MAX_DATA_OR_CRC_LEN + 6);
  localparam logic [PC_W-1:0]  PRE_MIN  = PC_W'(MIN_PREAMBLE_LEN);
  localparam logic [PC_W-1:0]  PRE_MAX  = PC_W'(PREAMBLE_LEN);
  localparam logic [DC_W-1:0]  DATA_MIN = DC_W'(MIN_DATA_OR_CRC_LEN);
  localparam logic [DC_W-1:0]  DATA_MAX = DC_W'(MAX_DATA_OR_CRC_LEN);
  localparam logic [LEN_W-1:0] PLD_MAX  = LEN_W'(MAX_DATA_OR_CRC_LEN);
`ifdef ETH_PARSER_VLAN_EN
  localparam logic [DC_W-1:0]  DATA_MAX_TAG = DC_W'(MAX_DATA_OR_CRC_LEN + 4);
  localparam logic [LEN_W-1:0] PLD_MAX_TAG  = LEN_W'(MAX_DATA_OR_CRC_LEN + 4);
`endif

  typedef enum logic [7:0] {
    IDLE              = 8'b0000_0001,
    PREAMBLE_PARSE    = 8'b0000_0010,
    DEST_MAC_PARSE    = 8'b0000_0100,
    SRC_MAC_PARSE     = 8'b0000_1000,
`ifdef ETH_PARSER_VLAN_EN
    VLAN_PARSE        = 8'b0001_0000,
`endif
    ETHER_TYPE_PARSE  = 8'b0010_0000,
    DATA_OR_CRC_PARSE = 8'b0100_0000,
    DROP              = 8'b1000_0000
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [2:0]       fld_cnt_q, fld_cnt_d;
  logic [47:0]      dest_sh_q, dest_sh_d;
  logic [47:0]      src_sh_q, src_sh_d;
  logic [7:0]       type_hi_q, type_hi_d;
  logic [DC_W-1:0]  data_cnt_q, data_cnt_d;
  logic [7:0]       dly_q [0:4];
  logic [7:0]       dly_d [0:4];
  logic [2:0]       dly_cnt_q, dly_cnt_d;
  logic [LEN_W-1:0] pld_cnt_q, pld_cnt_d;
  logic             err_rx_q, err_rx_d;
  logic             err_sfd_q, err_sfd_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic [47:0]      dest_mac_q, dest_mac_d;
  logic [47:0]      src_mac_q, src_mac_d;
  logic [15:0]      ether_type_q, ether_type_d;
  logic             pld_valid_q, pld_valid_d;
  logic [7:0]       pld_data_q, pld_data_d;
  logic             pld_first_q, pld_first_d;
  logic             pld_last_q, pld_last_d;
  logic             frame_done_q, frame_done_d;
  logic [4:0]       frame_err_q, frame_err_d;
  logic [LEN_W-1:0] pld_len_q, pld_len_d;
  logic [DC_W-1:0]  data_max_s;
  logic [LEN_W-1:0] pld_max_s;
  logic             hdr_done_s;
  logic [4:0]       err_s;
  logic [LEN_W-1:0] len_s;
`ifdef ETH_PARSER_VLAN_EN
  logic [15:0]      tci_sh_q, tci_sh_d;
  logic             vlan_seen_q, vlan_seen_d;
  logic             vlan_present_q, vlan_present_d;
  logic [15:0]      vlan_tci_q, vlan_tci_d;

  assign data_max_s   = vlan_seen_q ? DATA_MAX_TAG : DATA_MAX;
  assign pld_max_s    = vlan_seen_q ? PLD_MAX_TAG : PLD_MAX;
  assign vlan_present = vlan_present_q;
  assign vlan_tci     = vlan_tci_q;
`else
  assign data_max_s   = DATA_MAX;
  assign pld_max_s    = PLD_MAX;
  assign vlan_present = 1'b0;
  assign vlan_tci     = 16'h0000;
`endif

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pre_cnt_q    <= {PC_W{1'b0}};
      fld_cnt_q    <= 3'd0;
      dest_sh_q    <= 48'h0;
      src_sh_q     <= 48'h0;
      type_hi_q    <= 8'h00;
      data_cnt_q   <= {DC_W{1'b0}};
      for (int i = 0; i < 5; i++) dly_q[i] <= 8'h00;
      dly_cnt_q    <= 3'd0;
      pld_cnt_q    <= {LEN_W{1'b0}};
      err_rx_q     <= 1'b0;
      err_sfd_q    <= 1'b0;
      hdr_valid_q  <= 1'b0;
      dest_mac_q   <= 48'h0;
      src_mac_q    <= 48'h0;
      ether_type_q <= 16'h0000;
      pld_valid_q  <= 1'b0;
      pld_data_q   <= 8'h00;
      pld_first_q  <= 1'b0;
      pld_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 5'b00000;
      pld_len_q    <= {LEN_W{1'b0}};
`ifdef ETH_PARSER_VLAN_EN
      tci_sh_q       <= 16'h0000;
      vlan_seen_q    <= 1'b0;
      vlan_present_q <= 1'b0;
      vlan_tci_q     <= 16'h0000;
`endif
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      fld_cnt_q    <= fld_cnt_d;
      dest_sh_q    <= dest_sh_d;
      src_sh_q     <= src_sh_d;
      type_hi_q    <= type_hi_d;
      data_cnt_q   <= data_cnt_d;
      for (int i = 0; i < 5; i++) dly_q[i] <= dly_d[i];
      dly_cnt_q    <= dly_cnt_d;
      pld_cnt_q    <= pld_cnt_d;
      err_rx_q     <= err_rx_d;
      err_sfd_q    <= err_sfd_d;
      hdr_valid_q  <= hdr_valid_d;
      dest_mac_q   <= dest_mac_d;
      src_mac_q    <= src_mac_d;
      ether_type_q <= ether_type_d;
      pld_valid_q  <= pld_valid_d;
      pld_data_q   <= pld_data_d;
      pld_first_q  <= pld_first_d;
      pld_last_q   <= pld_last_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      pld_len_q    <= pld_len_d;
`ifdef ETH_PARSER_VLAN_EN
      tci_sh_q       <= tci_sh_d;
      vlan_seen_q    <= vlan_seen_d;
      vlan_present_q <= vlan_present_d;
      vlan_tci_q     <= vlan_tci_d;
`endif
    end
  end

  // Next-state, field capture, delay buffer and end-of-frame status
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    fld_cnt_d    = fld_cnt_q;
    dest_sh_d    = dest_sh_q;
    src_sh_d     = src_sh_q;
    type_hi_d    = type_hi_q;
    data_cnt_d   = data_cnt_q;
    dly_d        = dly_q;
    dly_cnt_d    = dly_cnt_q;
    pld_cnt_d    = pld_cnt_q;
    err_rx_d     = err_rx_q;
    err_sfd_d    = err_sfd_q;
    hdr_valid_d  = 1'b0;
    dest_mac_d   = dest_mac_q;
    src_mac_d    = src_mac_q;
    ether_type_d = ether_type_q;
    pld_valid_d  = 1'b0;
    pld_data_d   = pld_data_q;
    pld_first_d  = 1'b0;
    pld_last_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    pld_len_d    = pld_len_q;
    hdr_done_s   = 1'b0;
    err_s        = 5'b00000;
    len_s        = pld_cnt_q;
`ifdef ETH_PARSER_VLAN_EN
    tci_sh_d       = tci_sh_q;
    vlan_seen_d    = vlan_seen_q;
    vlan_present_d = vlan_present_q;
    vlan_tci_d     = vlan_tci_q;
`endif

    if (state_q == IDLE) begin
      if (gmii_rx_dv) begin
        fld_cnt_d  = 3'd0;
        data_cnt_d = {DC_W{1'b0}};
        dly_cnt_d  = 3'd0;
        pld_cnt_d  = {LEN_W{1'b0}};
        err_rx_d   = 1'b0;
`ifdef ETH_PARSER_VLAN_EN
        vlan_seen_d = 1'b0;
`endif
        if (gmii_rxd == 8'hAA) begin
          state_d   = PREAMBLE_PARSE;
          pre_cnt_d = PC_W'(1);
          err_sfd_d = 1'b0;
        end else begin
          state_d   = DROP;
          err_sfd_d = 1'b1;
        end
      end else begin
        state_d = IDLE;
      end
    end else if (!gmii_rx_dv) begin
      state_d      = IDLE;
      frame_done_d = 1'b1;
      err_s        = {err_rx_q, 3'b000, err_sfd_q};
      if (state_q == DATA_OR_CRC_PARSE) begin
        err_s[2] = (data_cnt_q < DATA_MIN);
        if (data_cnt_q > data_max_s) begin
          err_s[3] = 1'b1;
        end else if (dly_cnt_q == 3'd5) begin
          // The oldest buffered byte is the last payload byte; the other four are FCS.
          pld_valid_d = 1'b1;
          pld_data_d  = dly_q[0];
          pld_first_d = (pld_cnt_q == {LEN_W{1'b0}});
          pld_last_d  = 1'b1;
          len_s       = pld_cnt_q + LEN_W'(1);
        end else begin
          err_s[1] = 1'b1;
        end
      end else if (state_q != DROP) begin
        err_s[1] = 1'b1;
      end else begin
        err_s[1] = 1'b0;
      end
      frame_err_d = err_s;
      pld_len_d   = len_s;
    end else if (gmii_rx_er) begin
      state_d  = DROP;
      err_rx_d = 1'b1;
    end else begin
      case (state_q)
        PREAMBLE_PARSE: begin
          if (gmii_rxd == 8'hAA && pre_cnt_q < PRE_MAX) begin
            pre_cnt_d = pre_cnt_q + PC_W'(1);
          end else if (gmii_rxd == 8'hAB && pre_cnt_q >= PRE_MIN) begin
            state_d = DEST_MAC_PARSE;
          end else begin
            state_d   = DROP;
            err_sfd_d = 1'b1;
          end
        end
        DEST_MAC_PARSE: begin
          dest_sh_d = {dest_sh_q[39:0], gmii_rxd};
          if (fld_cnt_q == 3'd5) begin
            fld_cnt_d = 3'd0;
            state_d   = SRC_MAC_PARSE;
          end else begin
            fld_cnt_d = fld_cnt_q + 3'd1;
          end
        end
        SRC_MAC_PARSE: begin
          src_sh_d = {src_sh_q[39:0], gmii_rxd};
          if (fld_cnt_q == 3'd5) begin
            fld_cnt_d = 3'd0;
            state_d   = ETHER_TYPE_PARSE;
          end else begin
            fld_cnt_d = fld_cnt_q + 3'd1;
          end
        end
        ETHER_TYPE_PARSE: begin
          if (fld_cnt_q == 3'd0) begin
            type_hi_d = gmii_rxd;
            fld_cnt_d = 3'd1;
          end else begin
            fld_cnt_d = 3'd0;
`ifdef ETH_PARSER_VLAN_EN
            // Only one tag is stripped; a second 8100 is reported as the EtherType.
            if ({type_hi_q, gmii_rxd} == 16'h8100 && !vlan_seen_q) begin
              state_d = VLAN_PARSE;
            end else begin
              hdr_done_s = 1'b1;
            end
`else
            hdr_done_s = 1'b1;
`endif
          end
        end
`ifdef ETH_PARSER_VLAN_EN
        VLAN_PARSE: begin
          tci_sh_d = {tci_sh_q[7:0], gmii_rxd};
          if (fld_cnt_q == 3'd1) begin
            fld_cnt_d   = 3'd0;
            vlan_seen_d = 1'b1;
            state_d     = ETHER_TYPE_PARSE;
          end else begin
            fld_cnt_d = 3'd1;
          end
        end
`endif
        DATA_OR_CRC_PARSE: begin
          if (data_cnt_q <= data_max_s) begin
            data_cnt_d = data_cnt_q + DC_W'(1);
          end else begin
            data_cnt_d = data_cnt_q;
          end
          if (dly_cnt_q == 3'd5) begin
            if (pld_cnt_q < pld_max_s) begin
              pld_valid_d = 1'b1;
              pld_data_d  = dly_q[0];
              pld_first_d = (pld_cnt_q == {LEN_W{1'b0}});
              pld_cnt_d   = pld_cnt_q + LEN_W'(1);
            end else begin
              pld_valid_d = 1'b0;
            end
            for (int i = 0; i < 4; i++) dly_d[i] = dly_q[i+1];
            dly_d[4] = gmii_rxd;
          end else begin
            dly_d[dly_cnt_q] = gmii_rxd;
            dly_cnt_d        = dly_cnt_q + 3'd1;
          end
        end
        DROP: begin
          state_d = DROP;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (hdr_done_s) begin
      state_d      = DATA_OR_CRC_PARSE;
      hdr_valid_d  = 1'b1;
      dest_mac_d   = dest_sh_q;
      src_mac_d    = src_sh_q;
      ether_type_d = {type_hi_q, gmii_rxd};
`ifdef ETH_PARSER_VLAN_EN
      vlan_present_d = vlan_seen_q;
      vlan_tci_d     = vlan_seen_q ? tci_sh_q : 16'h0000;
`endif
    end else begin
      hdr_valid_d = 1'b0;
    end
  end

  assign hdr_valid  = hdr_valid_q;
  assign dest_mac   = dest_mac_q;
  assign src_mac    = src_mac_q;
  assign ether_type = ether_type_q;
  assign pld_valid  = pld_valid_q;
  assign pld_data   = pld_data_q;
  assign pld_first  = pld_first_q;
  assign pld_last   = pld_last_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign pld_len    = pld_len_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed self-checking bench for eth_rx_frame_parser; expectations follow ETH_PARSER_VLAN_EN when defined.
module tb_eth_rx_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic        hdr_valid, vlan_present, pld_valid, pld_first, pld_last, frame_done;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] ether_type, vlan_tci;
  logic [7:0]  pld_data;
  logic [4:0]  frame_err;
  logic [10:0] pld_len;

  localparam logic [47:0] DA = 48'h001122334455;
  localparam logic [47:0] SA = 48'h66778899AABB;

  int n_cmp = 0;
  int n_bad = 0;

  eth_rx_frame_parser dut (
    .clk(clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .hdr_valid(hdr_valid), .dest_mac(dest_mac), .src_mac(src_mac), .ether_type(ether_type),
    .vlan_present(vlan_present), .vlan_tci(vlan_tci), .pld_valid(pld_valid), .pld_data(pld_data),
    .pld_first(pld_first), .pld_last(pld_last), .frame_done(frame_done), .frame_err(frame_err),
    .pld_len(pld_len)
  );

  always #5 clk = ~clk;

  // Output recorder, sampled on the falling edge
  logic [7:0] pq[$];
  int dlen[$];
  int derr[$];
  int hdr_cnt, first_cnt, first_idx, last_cnt, last_idx;

  always @(negedge clk) begin
    if (hdr_valid) hdr_cnt++;
    if (pld_valid) begin
      if (pld_first) begin first_cnt++; first_idx = pq.size(); end
      if (pld_last) begin last_cnt++; last_idx = pq.size(); end
      pq.push_back(pld_data);
    end
    if (frame_done) begin
      dlen.push_back(int'(pld_len));
      derr.push_back(int'(frame_err));
    end
  end

  task automatic clear_mon();
    pq.delete(); dlen.delete(); derr.delete();
    hdr_cnt = 0; first_cnt = 0; first_idx = -1; last_cnt = 0; last_idx = -1;
  endtask

  function automatic int len_at(input int i);
    return (dlen.size() > i) ? dlen[i] : -1;
  endfunction

  function automatic int err_at(input int i);
    return (derr.size() > i) ? derr[i] : -1;
  endfunction

  function automatic int pq_at(input int i);
    return (pq.size() > i) ? int'(pq[i]) : -1;
  endfunction

  // First index k < n where pq[base+k] differs from the k & 8'hFF pattern, or -1
  function automatic int bad_idx(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      if (pq.size() <= base + k) return k;
      if (pq[base+k] !== 8'(k)) return k;
    end
    return -1;
  endfunction

  logic [7:0] fq[$];

  task automatic build_hdr(input int npre, input logic [15:0] et);
    fq.delete();
    for (int i = 0; i < npre; i++) fq.push_back(8'hAA);
    fq.push_back(8'hAB);
    for (int i = 5; i >= 0; i--) fq.push_back(DA[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fq.push_back(SA[i*8 +: 8]);
    fq.push_back(et[15:8]);
    fq.push_back(et[7:0]);
  endtask

  task automatic push_data(input int n);
    for (int i = 0; i < n; i++) fq.push_back(8'(i));
  endtask

  task automatic tx(input int er_at, input int ngap);
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1; gmii_rx_er = (i == er_at); gmii_rxd = fq[i];
    end
    for (int i = 0; i < ngap; i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (hdr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_hdr_valid got %b want 0", hdr_valid); end
    n_cmp++; if (dest_mac !== 48'h0) begin n_bad++; $display("FAIL rst_dest_mac got %h want 0", dest_mac); end
    n_cmp++; if (ether_type !== 16'h0) begin n_bad++; $display("FAIL rst_ether_type got %h want 0", ether_type); end
    n_cmp++; if (pld_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pld_valid got %b want 0", pld_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    n_cmp++; if (frame_err !== 5'b0 || pld_len !== 11'd0) begin n_bad++; $display("FAIL rst_status got err=%b len=%0d want 0/0", frame_err, pld_len); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_mon();
    build_hdr(7, 16'h0800); push_data(50); tx(-1, 4);
    n_cmp++; if (hdr_cnt !== 1) begin n_bad++; $display("FAIL basic_hdr_cnt got %0d want 1", hdr_cnt); end
    n_cmp++; if (dest_mac !== DA) begin n_bad++; $display("FAIL basic_dest_mac got %h want %h", dest_mac, DA); end
    n_cmp++; if (src_mac !== SA) begin n_bad++; $display("FAIL basic_src_mac got %h want %h", src_mac, SA); end
    n_cmp++; if (ether_type !== 16'h0800) begin n_bad++; $display("FAIL basic_ether_type got %h want 0800", ether_type); end
    n_cmp++; if (vlan_present !== 1'b0 || vlan_tci !== 16'h0) begin n_bad++; $display("FAIL basic_vlan got %b/%h want 0/0000", vlan_present, vlan_tci); end
    n_cmp++; if (pq.size() !== 46) begin n_bad++; $display("FAIL basic_pld_count got %0d want 46", pq.size()); end
    n_cmp++; if (bad_idx(0, 46) !== -1) begin n_bad++; $display("FAIL basic_pld_bytes first bad index %0d want -1", bad_idx(0, 46)); end
    n_cmp++; if (first_cnt !== 1 || first_idx !== 0) begin n_bad++; $display("FAIL basic_first got cnt=%0d idx=%0d want 1/0", first_cnt, first_idx); end
    n_cmp++; if (last_cnt !== 1 || last_idx !== 45) begin n_bad++; $display("FAIL basic_last got cnt=%0d idx=%0d want 1/45", last_cnt, last_idx); end
    n_cmp++; if (dlen.size() !== 1) begin n_bad++; $display("FAIL basic_done_cnt got %0d want 1", dlen.size()); end
    n_cmp++; if (err_at(0) !== 0) begin n_bad++; $display("FAIL basic_err got %0d want 0", err_at(0)); end
    n_cmp++; if (len_at(0) !== 46) begin n_bad++; $display("FAIL basic_len got %0d want 46", len_at(0)); end
  endtask

  task automatic test_preamble();
    clear_mon();
    build_hdr(5, 16'h0800); push_data(50); tx(-1, 4);
    n_cmp++; if (err_at(0) !== 0 || len_at(0) !== 46) begin n_bad++; $display("FAIL pre5 got err=%0d len=%0d want 0/46", err_at(0), len_at(0)); end
    clear_mon();
    build_hdr(4, 16'h0800); push_data(50); tx(-1, 4);
    n_cmp++; if (err_at(0) !== 1) begin n_bad++; $display("FAIL pre4_err got %0d want 1", err_at(0)); end
    n_cmp++; if (pq.size() !== 0 || hdr_cnt !== 0) begin n_bad++; $display("FAIL pre4_quiet got pld=%0d hdr=%0d want 0/0", pq.size(), hdr_cnt); end
    clear_mon();
    build_hdr(8, 16'h0800); push_data(50); tx(-1, 4);
    n_cmp++; if (err_at(0) !== 1 || pq.size() !== 0) begin n_bad++; $display("FAIL pre8 got err=%0d pld=%0d want 1/0", err_at(0), pq.size()); end
  endtask

  task automatic test_runt_incomplete();
    clear_mon();
    build_hdr(7, 16'h0800); push_data(30); tx(-1, 4);
    n_cmp++; if (err_at(0) !== 4) begin n_bad++; $display("FAIL runt_err got %0d want 4", err_at(0)); end
    n_cmp++; if (len_at(0) !== 26 || pq.size() !== 26) begin n_bad++; $display("FAIL runt_len got len=%0d pld=%0d want 26/26", len_at(0), pq.size()); end
    n_cmp++; if (last_cnt !== 1) begin n_bad++; $display("FAIL runt_last got %0d want 1", last_cnt); end
    clear_mon();
    build_hdr(7, 16'h0800);
    while (fq.size() > 17) void'(fq.pop_back());
    tx(-1, 4);
    n_cmp++; if (err_at(0) !== 2) begin n_bad++; $display("FAIL incomplete_err got %0d want 2", err_at(0)); end
    n_cmp++; if (hdr_cnt !== 0 || pq.size() !== 0) begin n_bad++; $display("FAIL incomplete_quiet got hdr=%0d pld=%0d want 0/0", hdr_cnt, pq.size()); end
  endtask

  task automatic test_vlan();
    clear_mon();
    build_hdr(7, 16'h8100);
    fq.push_back(8'h60); fq.push_back(8'h64); fq.push_back(8'h86); fq.push_back(8'hDD);
    push_data(1504); tx(-1, 4);
`ifdef ETH_PARSER_VLAN_EN
    n_cmp++; if (ether_type !== 16'h86DD) begin n_bad++; $display("FAIL vlan_type got %h want 86DD", ether_type); end
    n_cmp++; if (vlan_present !== 1'b1 || vlan_tci !== 16'h6064) begin n_bad++; $display("FAIL vlan_tag got %b/%h want 1/6064", vlan_present, vlan_tci); end
    n_cmp++; if (err_at(0) !== 0 || len_at(0) !== 1500) begin n_bad++; $display("FAIL vlan_status got err=%0d len=%0d want 0/1500", err_at(0), len_at(0)); end
    n_cmp++; if (bad_idx(0, 1500) !== -1 || last_cnt !== 1) begin n_bad++; $display("FAIL vlan_pld got bad=%0d last=%0d want -1/1", bad_idx(0, 1500), last_cnt); end
`else
    n_cmp++; if (ether_type !== 16'h8100) begin n_bad++; $display("FAIL notag_type got %h want 8100", ether_type); end
    n_cmp++; if (vlan_present !== 1'b0 || vlan_tci !== 16'h0) begin n_bad++; $display("FAIL notag_vlan got %b/%h want 0/0000", vlan_present, vlan_tci); end
    n_cmp++; if (pq_at(0) !== 8'h60 || pq_at(1) !== 8'h64 || pq_at(2) !== 8'h86 || pq_at(3) !== 8'hDD) begin
      n_bad++; $display("FAIL notag_head got %0h %0h %0h %0h want 60 64 86 dd", pq_at(0), pq_at(1), pq_at(2), pq_at(3)); end
    n_cmp++; if (err_at(0) !== 8 || len_at(0) !== 1503) begin n_bad++; $display("FAIL notag_status got err=%0d len=%0d want 8/1503", err_at(0), len_at(0)); end
    n_cmp++; if (bad_idx(4, 1499) !== -1 || last_cnt !== 0) begin n_bad++; $display("FAIL notag_pld got bad=%0d last=%0d want -1/0", bad_idx(4, 1499), last_cnt); end
`endif
  endtask

  task automatic test_oversize_rx_er();
    int er_at;
    clear_mon();
    build_hdr(7, 16'h0800); push_data(1509); tx(-1, 4);
    n_cmp++; if (err_at(0) !== 8) begin n_bad++; $display("FAIL over_err got %0d want 8", err_at(0)); end
    n_cmp++; if (len_at(0) !== 1504 || pq.size() !== 1504) begin n_bad++; $display("FAIL over_len got len=%0d pld=%0d want 1504/1504", len_at(0), pq.size()); end
    n_cmp++; if (last_cnt !== 0 || bad_idx(0, 1504) !== -1) begin n_bad++; $display("FAIL over_pld got last=%0d bad=%0d want 0/-1", last_cnt, bad_idx(0, 1504)); end
    clear_mon();
    build_hdr(7, 16'h0800); er_at = fq.size() + 20; push_data(50); tx(er_at, 4);
    n_cmp++; if (err_at(0) !== 16) begin n_bad++; $display("FAIL rxer_err got %0d want 16", err_at(0)); end
    n_cmp++; if (len_at(0) !== 15 || pq.size() !== 15) begin n_bad++; $display("FAIL rxer_len got len=%0d pld=%0d want 15/15", len_at(0), pq.size()); end
    n_cmp++; if (last_cnt !== 0 || hdr_cnt !== 1) begin n_bad++; $display("FAIL rxer_flags got last=%0d hdr=%0d want 0/1", last_cnt, hdr_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    build_hdr(7, 16'h0800); push_data(50); tx(-1, 1);
    build_hdr(7, 16'h0806); push_data(60); tx(-1, 4);
    n_cmp++; if (dlen.size() !== 2 || hdr_cnt !== 2) begin n_bad++; $display("FAIL b2b_count got done=%0d hdr=%0d want 2/2", dlen.size(), hdr_cnt); end
    n_cmp++; if (len_at(0) !== 46 || len_at(1) !== 56) begin n_bad++; $display("FAIL b2b_len got %0d/%0d want 46/56", len_at(0), len_at(1)); end
    n_cmp++; if (err_at(0) !== 0 || err_at(1) !== 0) begin n_bad++; $display("FAIL b2b_err got %0d/%0d want 0/0", err_at(0), err_at(1)); end
    n_cmp++; if (bad_idx(46, 56) !== -1 || ether_type !== 16'h0806) begin n_bad++; $display("FAIL b2b_second got bad=%0d type=%h want -1/0806", bad_idx(46, 56), ether_type); end
  endtask

  task automatic test_reset_mid_frame();
    build_hdr(7, 16'h0800); push_data(50);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1; gmii_rx_er = 1'b0; gmii_rxd = fq[i];
    end
    @(negedge clk);
    rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
    @(negedge clk);
    n_cmp++; if (pld_valid !== 1'b0 || pld_data !== 8'h00 || frame_done !== 1'b0) begin n_bad++; $display("FAIL midrst_pld got v=%b d=%h done=%b want 0/00/0", pld_valid, pld_data, frame_done); end
    n_cmp++; if (dest_mac !== 48'h0 || ether_type !== 16'h0 || pld_len !== 11'd0) begin n_bad++; $display("FAIL midrst_hdr got %h/%h/%0d want 0/0/0", dest_mac, ether_type, pld_len); end
    rst_n = 1'b1;
    clear_mon();
    @(negedge clk);
    tx(-1, 4);
    n_cmp++; if (dlen.size() !== 1 || err_at(0) !== 0 || len_at(0) !== 46) begin n_bad++; $display("FAIL midrst_next got done=%0d err=%0d len=%0d want 1/0/46", dlen.size(), err_at(0), len_at(0)); end
    n_cmp++; if (dest_mac !== DA || bad_idx(0, 46) !== -1) begin n_bad++; $display("FAIL midrst_data got da=%h bad=%0d want %h/-1", dest_mac, bad_idx(0, 46), DA); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preamble();
    test_runt_incomplete();
    test_vlan();
    test_oversize_rx_er();
    test_back_to_back();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1);
  end

endmodule
